id_rndn_gen: RTL

ID_RNDN_GEN -- requirements
Module: id_rndn_gen

---
 rtl/id_rndn_gen.sv | 119 +++++++++++
 1 files changed

// File: rtl/id_rndn_gen.sv
// Burst-oriented 32-bit Galois LFSR random word source with ready/valid handshake.
// Optional range mask on the output word is enabled by defining ID_RNDN_RANGE_EN.
module id_rndn_gen #(
    parameter int          CNT_W        = 16,
    parameter logic [31:0] SEED_DEFAULT = 32'hACE10001
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic [31:0]      seed,
    input  logic             seed_load,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] count,
`ifdef ID_RNDN_RANGE_EN
    input  logic [31:0]      range_mask,
`endif
    output logic [31:0]      rnd_data,
    output logic             rnd_valid,
    input  logic             rnd_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] gen_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [31:0]       lfsr;
    logic [CNT_W-1:0]  remaining;
    logic              seed_ok;
    logic              start_ok;
    logic              xfer;

    function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
        return (cur >> 1) ^ (cur[0] ? 32'h80200003 : 32'h0);
    endfunction

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        seed_ok   = 1'b0;
        start_ok  = 1'b0;
        xfer      = 1'b0;
        case (state)
            IDLE: begin
                seed_ok = seed_load;
                if (start) begin
                    start_ok  = 1'b1;
                    state_nxt = (count != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                xfer = rnd_ready;
                // Abort wins over a final transfer: no done pulse after abort.
                if (abort)
                    state_nxt = IDLE;
                else if (xfer && remaining == CNT_W'(1))
                    state_nxt = DONE;
            end
            DONE: begin
                seed_ok   = seed_load;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= IDLE;
            lfsr      <= SEED_DEFAULT;
            remaining <= '0;
            gen_cnt   <= '0;
        end else begin
            state <= state_nxt;

            // A zero seed would lock the LFSR at zero forever.
            if (seed_ok)
                lfsr <= (seed == 32'h0) ? SEED_DEFAULT : seed;
            else if (xfer)
                lfsr <= lfsr_step(lfsr);

            if (start_ok) begin
                remaining <= count;
                gen_cnt   <= '0;
            end else if (xfer) begin
                remaining <= remaining - CNT_W'(1);
                gen_cnt   <= gen_cnt + CNT_W'(1);
            end
        end
    end

`ifdef ID_RNDN_RANGE_EN
    logic [31:0] mask_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)
            mask_q <= '1;
        else if (start_ok)
            mask_q <= range_mask;
    end

    assign rnd_data = lfsr & mask_q;
`else
    assign rnd_data = lfsr;
`endif

    assign rnd_valid = (state == RUN);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

endmodule
